// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grant of up to two register-file write
// ports per cycle, with x0 requests drained without consuming a port.
module wb_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_hold,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0][4:0]  req_rd,
    input  logic [N_REQ-1:0][31:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [1:0][4:0]        wa,
    output logic [1:0][31:0]       wd
);

    localparam int PW = $clog2(N_REQ);

    typedef logic [PW-1:0] idx_t;

    idx_t       ptr;
    idx_t       ptr_next;
    idx_t       last;
    idx_t       sel0;
    idx_t       sel1;
    logic       hit0;
    logic       hit1;
    logic [4:0] rd0;

    // Scan from ptr; the second port must target a different register.
    always_comb begin
        int   j;
        idx_t i;
        req_ready = '0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        sel0      = '0;
        sel1      = '0;
        rd0       = '0;
        j         = 0;
        i         = '0;
        if (!reset && !wb_hold) begin
            for (int k = 0; k < N_REQ; k++) begin
                j = int'(ptr) + k;
                if (j >= N_REQ) begin
                    j = j - N_REQ;
                end
                i = idx_t'(j);
                if (req_valid[i]) begin
                    if (req_rd[i] == 5'd0) begin
                        req_ready[i] = 1'b1;
                    end else if (!hit0) begin
                        hit0         = 1'b1;
                        sel0         = i;
                        rd0          = req_rd[i];
                        req_ready[i] = 1'b1;
                    end else if (!hit1 && req_rd[i] != rd0) begin
                        hit1         = 1'b1;
                        sel1         = i;
                        req_ready[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        last     = hit1 ? sel1 : sel0;
        ptr_next = ptr;
        if (hit0) begin
            if (int'(last) == N_REQ - 1) begin
                ptr_next = '0;
            end else begin
                ptr_next = last + idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            wa  <= '0;
            wd  <= '0;
        end else begin
            ptr   <= ptr_next;
            wa[0] <= hit0 ? req_rd[sel0]   : 5'd0;
            wd[0] <= hit0 ? req_data[sel0] : 32'd0;
            wa[1] <= hit1 ? req_rd[sel1]   : 5'd0;
            wd[1] <= hit1 ? req_data[sel1] : 32'd0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic,
// all checked against a round-robin reference model.
module tb_wb_arbiter;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               wb_hold;
    logic [N-1:0]       req_valid;
    logic [N-1:0][4:0]  req_rd;
    logic [N-1:0][31:0] req_data;
    logic [N-1:0]       req_ready;
    logic [1:0][4:0]    wa;
    logic [1:0][31:0]   wd;

    int vectors = 0;
    int miscompares = 0;

    int          m_ptr;
    logic [4:0]  e_wa [2];
    logic [31:0] e_wd [2];
    logic [N-1:0] g_rdy;
    int          g_s0;
    int          g_s1;

    wb_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_hold   (wb_hold),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wa        (wa),
        .wd        (wd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec-level model: list requesters in round-robin order, keep the
    // valid ones, then hand out x0 passes and two distinct-rd slots.
    task automatic model_eval(output logic [N-1:0] rdy,
                              output int s0, output int s1);
        int order[$];
        int i;
        rdy = '0;
        s0  = -1;
        s1  = -1;
        if (reset || wb_hold) return;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
        end
        foreach (order[q]) begin
            i = order[q];
            if (req_rd[i] == 5'd0) begin
                rdy[i] = 1'b1;
            end else if (s0 < 0) begin
                s0     = i;
                rdy[i] = 1'b1;
            end else if (s1 < 0 && req_rd[i] != req_rd[s0]) begin
                s1     = i;
                rdy[i] = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        e_wa[0] = '0;
        e_wa[1] = '0;
        e_wd[0] = '0;
        e_wd[1] = '0;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd,
                           input logic [31:0] data);
        req_valid[i] = 1'b1;
        req_rd[i]    = rd;
        req_data[i]  = data;
    endtask

    task automatic settle_check(input string tag);
        #1;
        model_eval(g_rdy, g_s0, g_s1);
        chk({tag, "_ready"}, 32'(req_ready), 32'(g_rdy));
        chk({tag, "_wa0"}, 32'(wa[0]), 32'(e_wa[0]));
        chk({tag, "_wa1"}, 32'(wa[1]), 32'(e_wa[1]));
        chk({tag, "_wd0"}, wd[0], e_wd[0]);
        chk({tag, "_wd1"}, wd[1], e_wd[1]);
    endtask

    task automatic advance();
        logic served;
        served = 1'b0;
        @(posedge clk);
        if (!reset) begin
            served  = 1'b1;
            e_wa[0] = (g_s0 >= 0) ? req_rd[g_s0]   : 5'd0;
            e_wd[0] = (g_s0 >= 0) ? req_data[g_s0] : 32'd0;
            e_wa[1] = (g_s1 >= 0) ? req_rd[g_s1]   : 5'd0;
            e_wd[1] = (g_s1 >= 0) ? req_data[g_s1] : 32'd0;
            if (g_s0 >= 0) m_ptr = (((g_s1 >= 0) ? g_s1 : g_s0) + 1) % N;
        end
        @(negedge clk);
        if (served) req_valid = req_valid & ~g_rdy;
    endtask

    task automatic all_valid();
        for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), $urandom);
    endtask

    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk({tag, "_async_wa0"}, 32'(wa[0]), 32'd0);
        chk({tag, "_async_wa1"}, 32'(wa[1]), 32'd0);
        chk({tag, "_async_wd0"}, wd[0], 32'd0);
        chk({tag, "_async_wd1"}, wd[1], 32'd0);
        chk({tag, "_async_rdy"}, 32'(req_ready), 32'd0);
        advance();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        wb_hold   = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        model_reset();
        @(negedge clk);
        all_valid();
        settle_check("rst");
        chk("rst_rdy_const", 32'(req_ready), 32'd0);
        advance();
        req_valid = '0;
        reset = 1'b0;

        set_req(2, 5'd5, 32'hDEADBEEF);
        settle_check("r31");
        chk("r31_rdy_const", 32'(req_ready), 32'h4);
        advance();
        settle_check("r31b");
        chk("r31_wa0_const", 32'(wa[0]), 32'd5);
        chk("r31_wd0_const", wd[0], 32'hDEADBEEF);
        chk("r31_wa1_const", 32'(wa[1]), 32'd0);
        advance();

        set_req(0, 5'd1, 32'h11);
        set_req(3, 5'd2, 32'h22);
        settle_check("p3");
        chk("p3_rdy_const", 32'(req_ready), 32'h9);
        advance();
        settle_check("p3b");
        chk("p3_wa0_const", 32'(wa[0]), 32'd2);
        chk("p3_wa1_const", 32'(wa[1]), 32'd1);
        advance();
        set_req(3, 5'd6, 32'h66);
        settle_check("p1");
        advance();

        all_valid();
        settle_check("r32a");
        chk("r32a_rdy_const", 32'(req_ready), 32'h3);
        advance();
        settle_check("r32b");
        chk("r32b_rdy_const", 32'(req_ready), 32'hC);
        chk("r32b_wa0_const", 32'(wa[0]), 32'd1);
        chk("r32b_wa1_const", 32'(wa[1]), 32'd2);
        advance();
        settle_check("r32c");
        chk("r32c_wa0_const", 32'(wa[0]), 32'd3);
        chk("r32c_wa1_const", 32'(wa[1]), 32'd4);
        advance();

        set_req(0, 5'd7, 32'h70);
        set_req(3, 5'd7, 32'h73);
        settle_check("ptr0");
        chk("ptr0_rdy_const", 32'(req_ready), 32'h1);
        advance();
        settle_check("ptr0b");
        advance();

        set_req(0, 5'd7, 32'hA0);
        set_req(1, 5'd7, 32'hA1);
        settle_check("r33a");
        chk("r33a_rdy_const", 32'(req_ready), 32'h1);
        advance();
        settle_check("r33b");
        chk("r33b_rdy_const", 32'(req_ready), 32'h2);
        chk("r33b_wa0_const", 32'(wa[0]), 32'd7);
        chk("r33b_wa1_const", 32'(wa[1]), 32'd0);
        advance();
        set_req(3, 5'd11, 32'hB3);
        settle_check("r33c");
        advance();

        set_req(0, 5'd8, 32'h80);
        set_req(1, 5'd0, 32'h81);
        set_req(2, 5'd9, 32'h92);
        set_req(3, 5'd10, 32'hA3);
        settle_check("r34a");
        chk("r34a_rdy_const", 32'(req_ready), 32'h7);
        advance();
        settle_check("r34b");
        chk("r34b_rdy_const", 32'(req_ready), 32'h8);
        chk("r34b_wa0_const", 32'(wa[0]), 32'd8);
        chk("r34b_wa1_const", 32'(wa[1]), 32'd9);
        advance();
        settle_check("r34c");
        advance();

        all_valid();
        wb_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle_check("r35h");
            chk("r35h_rdy_const", 32'(req_ready), 32'd0);
            advance();
        end
        wb_hold = 1'b0;
        settle_check("r35r");
        chk("r35r_rdy_const", 32'(req_ready), 32'h3);
        chk("r35r_wa0_const", 32'(wa[0]), 32'd0);
        advance();
        settle_check("r35s");
        advance();
        settle_check("r35t");
        advance();

        all_valid();
        settle_check("r36a");
        advance();
        set_req(0, 5'd5, 32'h55);
        set_req(1, 5'd6, 32'h66);
        settle_check("r36b");
        chk("r36b_rdy_const", 32'(req_ready), 32'hC);
        mid_reset("r36");
        settle_check("r36c");
        chk("r36c_rdy_const", 32'(req_ready), 32'h3);
        advance();
        settle_check("r36d");
        advance();
        settle_check("r36e");
        advance();

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 5'($urandom_range(0, 7)), $urandom);
            end
            wb_hold = ($urandom_range(0, 7) == 0);
            settle_check("rnd");
            if (c % 97 == 50) mid_reset("rnd");
            else advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
